// File: rtl/axi_seq_msg_master.sv
// rtl/axi_seq_msg_master.sv - AXI-Lite master sequencer streaming boot/runtime byte messages to a UART TX slave
module axi_seq_msg_master #(
    parameter int           AW         = 32,
    parameter int           DW         = 32,
    parameter logic [31:0]  UART_BASE  = 32'h4000_0000,
    parameter logic [31:0]  TXDATA_OFS = 32'h0,
    parameter logic [31:0]  STATUS_OFS = 32'h4,
    parameter int           BUSY_BIT   = 0,
    parameter int           MSG_DEPTH  = 32,
    parameter int           PW         = $clog2(MSG_DEPTH),
    parameter bit           BOOT_EN    = 1'b1,
    parameter int           BOOT_LEN   = 6,
    parameter logic [127:0] BOOT_STR   = {80'h0, "HELLO\n"},
    parameter int           POLL_MAX   = 1024
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_we,
    input  logic [PW-1:0]     cfg_addr,
    input  logic [7:0]        cfg_data,
    input  logic              start,
    input  logic [PW-1:0]     start_ptr,
    input  logic [PW:0]       start_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [PW:0]       sent_cnt,
    output logic [AW-1:0]     M_AWADDR,
    output logic              M_AWVALID,
    input  logic              M_AWREADY,
    output logic [DW-1:0]     M_WDATA,
    output logic [DW/8-1:0]   M_WSTRB,
    output logic              M_WVALID,
    input  logic              M_WREADY,
    input  logic [1:0]        M_BRESP,
    input  logic              M_BVALID,
    output logic              M_BREADY,
    output logic [AW-1:0]     M_ARADDR,
    output logic              M_ARVALID,
    input  logic              M_ARREADY,
    input  logic [DW-1:0]     M_RDATA,
    input  logic [1:0]        M_RRESP,
    input  logic              M_RVALID,
    output logic              M_RREADY
);
    localparam int IW  = (PW + 1 > 5) ? PW + 1 : 5;
    localparam int PCW = $clog2(POLL_MAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_POLL_AR = 3'd2;
    localparam logic [2:0] S_POLL_R  = 3'd3;
    localparam logic [2:0] S_WR_AW_W = 3'd4;
    localparam logic [2:0] S_WR_B    = 3'd5;
    localparam logic [2:0] S_NEXT    = 3'd6;

    localparam logic [AW-1:0] STATUS_ADDR = AW'(UART_BASE + STATUS_OFS);
    localparam logic [AW-1:0] TX_ADDR     = AW'(UART_BASE + TXDATA_OFS);

    logic [2:0]     state;
    logic [7:0]     ram [MSG_DEPTH];
    logic [PW-1:0]  ptr_q;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  len_q;
    logic [IW-1:0]  idx_inc;
    logic [PW-1:0]  ram_addr;
    logic           boot_pend;
    logic           boot_mode;
    logic [7:0]     byte_q;
    logic [7:0]     boot_byte;
    logic [PCW-1:0] poll_cnt;
    int             boot_sel;

    wire unused_rdata = ^M_RDATA;

    always_comb begin
        ram_addr = ptr_q + idx_q[PW-1:0];
        idx_inc  = idx_q + 1'b1;
        // First boot character lives in the MSBs of the used BOOT_LEN*8 bits
        boot_sel = BOOT_LEN - 1 - int'(idx_q[3:0]);
        if (boot_sel < 0) boot_sel = 0;
        boot_byte = BOOT_STR[boot_sel*8 +: 8];
    end

    always_ff @(posedge ACLK) begin
        if (cfg_we) ram[cfg_addr] <= cfg_data;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            sent_cnt  <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            boot_pend <= BOOT_EN;
            boot_mode <= 1'b0;
            byte_q    <= '0;
            poll_cnt  <= '0;
            M_AWADDR  <= '0;
            M_AWVALID <= 1'b0;
            M_WDATA   <= '0;
            M_WSTRB   <= '0;
            M_WVALID  <= 1'b0;
            M_BREADY  <= 1'b0;
            M_ARADDR  <= '0;
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (boot_pend) begin
                        boot_pend <= 1'b0;
                        boot_mode <= 1'b1;
                        ptr_q     <= '0;
                        idx_q     <= '0;
                        len_q     <= IW'(BOOT_LEN);
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        sent_cnt  <= '0;
                        busy      <= 1'b1;
                        state     <= S_FETCH;
                    end else if (start) begin
                        boot_mode <= 1'b0;
                        ptr_q     <= start_ptr;
                        idx_q     <= '0;
                        len_q     <= IW'(start_len);
                        err       <= 1'b0;
                        err_code  <= 2'b00;
                        sent_cnt  <= '0;
                        if (start_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    byte_q    <= boot_mode ? boot_byte : ram[ram_addr];
                    M_ARADDR  <= STATUS_ADDR;
                    M_ARVALID <= 1'b1;
                    state     <= S_POLL_AR;
                end
                S_POLL_AR: begin
                    if (M_ARREADY) begin
                        M_ARVALID <= 1'b0;
                        M_RREADY  <= 1'b1;
                        state     <= S_POLL_R;
                    end
                end
                S_POLL_R: begin
                    if (M_RVALID) begin
                        M_RREADY <= 1'b0;
                        if (M_RRESP != 2'b00) begin
                            err       <= 1'b1;
                            err_code  <= 2'b10;
                            busy      <= 1'b0;
                            boot_mode <= 1'b0;
                            poll_cnt  <= '0;
                            state     <= S_IDLE;
                        end else if (M_RDATA[BUSY_BIT]) begin
                            if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                                err       <= 1'b1;
                                err_code  <= 2'b01;
                                busy      <= 1'b0;
                                boot_mode <= 1'b0;
                                poll_cnt  <= '0;
                                state     <= S_IDLE;
                            end else begin
                                poll_cnt  <= poll_cnt + 1'b1;
                                M_ARVALID <= 1'b1;
                                state     <= S_POLL_AR;
                            end
                        end else begin
                            poll_cnt  <= '0;
                            M_AWADDR  <= TX_ADDR;
                            M_AWVALID <= 1'b1;
                            M_WDATA   <= DW'(byte_q);
                            M_WSTRB   <= (DW/8)'(1);
                            M_WVALID  <= 1'b1;
                            state     <= S_WR_AW_W;
                        end
                    end
                end
                S_WR_AW_W: begin
                    // AW and W retire independently; move on once neither is still pending
                    if (M_AWREADY) M_AWVALID <= 1'b0;
                    if (M_WREADY)  M_WVALID  <= 1'b0;
                    if ((!M_AWVALID || M_AWREADY) && (!M_WVALID || M_WREADY)) begin
                        M_BREADY <= 1'b1;
                        state    <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (M_BVALID) begin
                        M_BREADY <= 1'b0;
                        if (M_BRESP != 2'b00) begin
                            err       <= 1'b1;
                            err_code  <= 2'b11;
                            busy      <= 1'b0;
                            boot_mode <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            sent_cnt <= sent_cnt + 1'b1;
                            state    <= S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    idx_q <= idx_inc;
                    if (idx_inc == len_q) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        boot_mode <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_seq_msg_master.sv
// tb/tb_axi_seq_msg_master.sv - directed bench for axi_seq_msg_master against a reactive UART slave model
module tb_axi_seq_msg_master;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        start = 1'b0;
    logic [4:0]  start_ptr = '0;
    logic [5:0]  start_len = '0;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [5:0]  sent_cnt;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
    logic        M_AWREADY = 1'b0, M_WREADY = 1'b0, M_BVALID = 1'b0, M_ARREADY = 1'b0, M_RVALID = 1'b0;
    logic [1:0]  M_BRESP = 2'b00, M_RRESP = 2'b00;
    logic [31:0] M_RDATA = '0;

    axi_seq_msg_master #(.POLL_MAX(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .start_ptr(start_ptr), .start_len(start_len),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .sent_cnt(sent_cnt),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    // slave configuration, written only by the tests
    int busy_per_byte = 0;
    bit stuck = 1'b0;
    int berr_at = -1;
    int aw_stall_cfg = 0;

    // slave bookkeeping, written only by the slave process
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, done_cnt = 0, viol_cnt = 0;
    int aw_hi = 0, w_hi = 0, polls_since_w = 0, aw_seen = 0;
    logic [31:0] w_log [256];
    logic [3:0]  strb_log [256];
    logic [31:0] aw_log [256];
    int          ar_at_aw [256];
    logic [31:0] last_araddr = '0;
    logic [31:0] hs_awaddr, hs_wdata, hs_araddr;
    logic [3:0]  hs_wstrb;
    bit f_ar, f_r, f_aw, f_w, f_b, r_pend, aw_got, w_got;

    logic [7:0] boot_exp [6] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};

    // Handshakes computed at a negedge complete at the following posedge and are consumed next negedge
    initial begin
        forever begin
            @(negedge ACLK);
            if (done === 1'b1) done_cnt++;
            if (ARESET) begin
                M_ARREADY = 0; M_RVALID = 0; M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0;
                f_ar = 0; f_r = 0; f_aw = 0; f_w = 0; f_b = 0;
                r_pend = 0; aw_got = 0; w_got = 0; aw_seen = 0; polls_since_w = 0;
            end else begin
                if (f_ar) begin ar_cnt++; last_araddr = hs_araddr; r_pend = 1; end
                if (f_r) M_RVALID = 0;
                if (f_aw) begin
                    aw_log[aw_cnt % 256] = hs_awaddr;
                    ar_at_aw[aw_cnt % 256] = ar_cnt;
                    aw_cnt++; aw_got = 1; polls_since_w = 0;
                end
                if (f_w) begin
                    w_log[w_cnt % 256] = hs_wdata;
                    strb_log[w_cnt % 256] = hs_wstrb;
                    w_cnt++; w_got = 1;
                end
                if (f_b) M_BVALID = 0;
                if (M_ARVALID && (M_AWVALID || M_WVALID)) viol_cnt++;
                if (M_AWVALID) aw_hi++;
                if (M_WVALID) w_hi++;
                M_ARREADY = M_ARVALID;
                if (r_pend && !M_RVALID) begin
                    M_RVALID = 1; M_RRESP = 2'b00;
                    M_RDATA = (stuck || polls_since_w < busy_per_byte) ? 32'h1 : 32'h0;
                    polls_since_w++; r_pend = 0;
                end
                if (M_AWVALID) begin
                    M_AWREADY = (aw_seen >= aw_stall_cfg);
                    aw_seen++;
                end else begin
                    M_AWREADY = 0; aw_seen = 0;
                end
                M_WREADY = M_WVALID;
                if (aw_got && w_got && !M_BVALID) begin
                    M_BVALID = 1;
                    M_BRESP = (b_cnt == berr_at) ? 2'b10 : 2'b00;
                    b_cnt++; aw_got = 0; w_got = 0;
                end
                f_ar = M_ARVALID && M_ARREADY; hs_araddr = M_ARADDR;
                f_r  = M_RVALID && M_RREADY;
                f_aw = M_AWVALID && M_AWREADY; hs_awaddr = M_AWADDR;
                f_w  = M_WVALID && M_WREADY; hs_wdata = M_WDATA; hs_wstrb = M_WSTRB;
                f_b  = M_BVALID && M_BREADY;
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge ACLK);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit timed_out);
        int c;
        c = 0;
        while (busy && c < max) begin
            @(negedge ACLK);
            c++;
        end
        timed_out = busy;
        settle(2);
    endtask

    task automatic start_msg(input logic [4:0] p, input logic [5:0] l);
        @(negedge ACLK);
        start = 1; start_ptr = p; start_len = l;
        @(negedge ACLK);
        start = 0;
    endtask

    task automatic load_ram();
        for (int i = 0; i < 32; i++) begin
            @(negedge ACLK);
            cfg_we = 1; cfg_addr = 5'(i); cfg_data = 8'(8'h41 + i);
        end
        @(negedge ACLK);
        cfg_we = 0;
    endtask

    task automatic test_reset();
        settle(3);
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
        n_cmp++; if ({err_code, sent_cnt} !== 8'h00) begin n_bad++; $display("FAIL reset_code_cnt: got %h want 00", {err_code, sent_cnt}); end
        n_cmp++; if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY} !== 5'b0) begin n_bad++; $display("FAIL reset_valids: got %b want 00000", {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY}); end
        n_cmp++; if ({M_AWADDR, M_WDATA, M_WSTRB} !== 68'h0) begin n_bad++; $display("FAIL reset_bus: got %h want 0", {M_AWADDR, M_WDATA, M_WSTRB}); end
    endtask

    task automatic check_boot(input string tag, input int wbase, input int awbase, input int dbase);
        n_cmp++; if (aw_cnt - awbase !== 6) begin n_bad++; $display("FAIL %s_aw_count: got %0d want 6", tag, aw_cnt - awbase); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (w_log[(wbase + i) % 256] !== {24'h0, boot_exp[i]} || strb_log[(wbase + i) % 256] !== 4'b0001 || aw_log[(awbase + i) % 256] !== 32'h4000_0000) begin
                n_bad++;
                $display("FAIL %s_byte%0d: got data %h strb %b addr %h want data %h strb 0001 addr 40000000", tag, i, w_log[(wbase + i) % 256], strb_log[(wbase + i) % 256], aw_log[(awbase + i) % 256], boot_exp[i]);
            end
        end
        n_cmp++; if (done_cnt - dbase !== 1) begin n_bad++; $display("FAIL %s_done: got %0d pulses want 1", tag, done_cnt - dbase); end
        n_cmp++; if (sent_cnt !== 6'd6 || err !== 1'b0) begin n_bad++; $display("FAIL %s_sent: got sent %0d err %b want 6 0", tag, sent_cnt, err); end
    endtask

    task automatic test_boot();
        int wb, ab, db;
        bit to;
        wb = w_cnt; ab = aw_cnt; db = done_cnt;
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL boot_busy: got %b want 1", busy); end
        start = 1; start_ptr = 0; start_len = 3;
        @(negedge ACLK);
        start = 0;
        wait_idle(3000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL boot_timeout: got busy want idle"); end
        settle(20);
        check_boot("boot", wb, ab, db);
    endtask

    task automatic test_poll_busy();
        int ab, arb;
        bit to;
        load_ram();
        busy_per_byte = 3;
        ab = aw_cnt; arb = ar_cnt;
        start_msg(5'd0, 6'd2);
        wait_idle(3000, to);
        busy_per_byte = 0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL poll_timeout_wait: got busy want idle"); end
        n_cmp++; if (ar_cnt - arb !== 8 || aw_cnt - ab !== 2) begin n_bad++; $display("FAIL poll_counts: got ar %0d aw %0d want 8 2", ar_cnt - arb, aw_cnt - ab); end
        n_cmp++; if (ar_at_aw[ab % 256] - arb !== 4 || ar_at_aw[(ab + 1) % 256] - arb !== 8) begin n_bad++; $display("FAIL poll_order: got %0d %0d want 4 8", ar_at_aw[ab % 256] - arb, ar_at_aw[(ab + 1) % 256] - arb); end
        n_cmp++; if (last_araddr !== 32'h4000_0004 || viol_cnt !== 0) begin n_bad++; $display("FAIL poll_addr: got %h viol %0d want 40000004 0", last_araddr, viol_cnt); end
        n_cmp++; if (w_log[(w_cnt - 2) % 256] !== 32'h41 || w_log[(w_cnt - 1) % 256] !== 32'h42) begin n_bad++; $display("FAIL poll_data: got %h %h want 41 42", w_log[(w_cnt - 2) % 256], w_log[(w_cnt - 1) % 256]); end
    endtask

    task automatic test_poll_timeout();
        int ab, arb, db;
        bit to;
        stuck = 1;
        ab = aw_cnt; arb = ar_cnt; db = done_cnt;
        start_msg(5'd0, 6'd1);
        wait_idle(2000, to);
        stuck = 0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL tmo_wait: got busy want idle"); end
        n_cmp++; if (ar_cnt - arb !== 8 || aw_cnt - ab !== 0) begin n_bad++; $display("FAIL tmo_counts: got ar %0d aw %0d want 8 0", ar_cnt - arb, aw_cnt - ab); end
        n_cmp++; if ({err, err_code, busy} !== 4'b1010 || done_cnt !== db) begin n_bad++; $display("FAIL tmo_status: got err %b code %b busy %b done %0d want 1 01 0 0", err, err_code, busy, done_cnt - db); end
    endtask

    task automatic test_bresp_err();
        int ab, db;
        bit to;
        berr_at = b_cnt + 1;
        ab = aw_cnt; db = done_cnt;
        start_msg(5'd0, 6'd4);
        wait_idle(3000, to);
        settle(20);
        berr_at = -1;
        n_cmp++; if (to) begin n_bad++; $display("FAIL berr_wait: got busy want idle"); end
        n_cmp++; if ({err, err_code} !== 3'b111 || sent_cnt !== 6'd1) begin n_bad++; $display("FAIL berr_status: got err %b code %b sent %0d want 1 11 1", err, err_code, sent_cnt); end
        n_cmp++; if (aw_cnt - ab !== 2 || done_cnt !== db) begin n_bad++; $display("FAIL berr_traffic: got aw %0d done %0d want 2 0", aw_cnt - ab, done_cnt - db); end
        start_msg(5'd0, 6'd1);
        n_cmp++; if (err !== 1'b0 || err_code !== 2'b00) begin n_bad++; $display("FAIL berr_clear: got err %b code %b want 0 00", err, err_code); end
        wait_idle(3000, to);
        n_cmp++; if (done_cnt - db !== 1 || err !== 1'b0) begin n_bad++; $display("FAIL berr_recover: got done %0d err %b want 1 0", done_cnt - db, err); end
    endtask

    task automatic test_wrap();
        int wb, ab, arb;
        bit to;
        logic [7:0] exp [4];
        exp = '{8'h5F, 8'h60, 8'h41, 8'h42};
        wb = w_cnt;
        start_msg(5'd30, 6'd4);
        wait_idle(3000, to);
        n_cmp++; if (to || w_cnt - wb !== 4) begin n_bad++; $display("FAIL wrap_count: got %0d writes timeout %b want 4 0", w_cnt - wb, to); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (w_log[(wb + i) % 256] !== {24'h0, exp[i]}) begin n_bad++; $display("FAIL wrap_byte%0d: got %h want %h", i, w_log[(wb + i) % 256], exp[i]); end
        end
        ab = aw_cnt; arb = ar_cnt;
        start_msg(5'd3, 6'd0);
        n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_len_done: got %b want 1", done); end
        settle(10);
        n_cmp++; if (aw_cnt !== ab || ar_cnt !== arb || busy !== 1'b0) begin n_bad++; $display("FAIL zero_len_traffic: got aw %0d ar %0d busy %b want 0 0 0", aw_cnt - ab, ar_cnt - arb, busy); end
    endtask

    task automatic test_aw_stall();
        int awh, wh, bb, wb;
        bit to;
        aw_stall_cfg = 5;
        awh = aw_hi; wh = w_hi; bb = b_cnt; wb = w_cnt;
        start_msg(5'd0, 6'd1);
        wait_idle(3000, to);
        aw_stall_cfg = 0;
        n_cmp++; if (to) begin n_bad++; $display("FAIL stall_wait: got busy want idle"); end
        n_cmp++; if (aw_hi - awh !== 6 || w_hi - wh !== 1) begin n_bad++; $display("FAIL stall_valid_cycles: got aw %0d w %0d want 6 1", aw_hi - awh, w_hi - wh); end
        n_cmp++; if (b_cnt - bb !== 1 || w_log[wb % 256] !== 32'h41 || sent_cnt !== 6'd1) begin n_bad++; $display("FAIL stall_b: got b %0d data %h sent %0d want 1 41 1", b_cnt - bb, w_log[wb % 256], sent_cnt); end
    endtask

    task automatic test_reset_mid_write();
        int c, wb, ab, db;
        bit to;
        aw_stall_cfg = 20;
        start_msg(5'd0, 6'd1);
        c = 0;
        while (!M_AWVALID && c < 200) begin
            @(negedge ACLK);
            c++;
        end
        n_cmp++; if (M_AWVALID !== 1'b1) begin n_bad++; $display("FAIL midrst_reach: got awvalid %b want 1", M_AWVALID); end
        #2 ARESET = 1;
        #1;
        n_cmp++; if ({M_AWVALID, M_WVALID, M_ARVALID, M_RREADY, M_BREADY, busy} !== 6'b0) begin n_bad++; $display("FAIL midrst_valids: got %b want 000000", {M_AWVALID, M_WVALID, M_ARVALID, M_RREADY, M_BREADY, busy}); end
        aw_stall_cfg = 0;
        settle(3);
        wb = w_cnt; ab = aw_cnt; db = done_cnt;
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        wait_idle(3000, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL midrst_wait: got busy want idle"); end
        check_boot("replay", wb, ab, db);
    endtask

    initial begin
        test_reset();
        test_boot();
        test_poll_busy();
        test_poll_timeout();
        test_bresp_err();
        test_wrap();
        test_aw_stall();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
